// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: definitions shared by the hazard scoreboard and its
// per-register entry: the halt FSM state encoding, the pipeline-age codes
// for a tracked write, the default register index width, and the rule that
// decides whether one source operand must wait.
package hazard_scoreboard_pkg;

  localparam int unsigned NB_REG_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] AGE_NONE = 2'd0;
  localparam logic [1:0] AGE_EX   = 2'd1;
  localparam logic [1:0] AGE_MEM  = 2'd2;
  localparam logic [1:0] AGE_WB   = 2'd3;

  // A non-branch consumer can only be fed by forwarding once a load has
  // reached MEM. A branch compares in ID, so it needs any ALU result to be
  // in MEM and a load result to be in WB.
  function automatic logic src_hazard(input logic       pend,
                                      input logic       is_load,
                                      input logic [1:0] age,
                                      input logic       branch);
    logic hz;
    hz = 1'b0;
    if (pend) begin
      if (branch) hz = (age == AGE_EX) || (is_load && (age == AGE_MEM));
      else        hz = is_load && (age == AGE_EX);
    end
    return hz;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// hazard_reg_entry: tracking state for one architectural register.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   issue_i         a producer of this register leaves ID this cycle
//   load_i          that producer is a load
//   pend_o          a write to this register is still in flight
//   load_o          the in-flight producer is a load
//   age_o           pipeline stage of the producer (EX/MEM/WB)
module hazard_reg_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       issue_i,
  input  logic       load_i,
  output logic       pend_o,
  output logic       load_o,
  output logic [1:0] age_o
);

  logic       pend_q, pend_d;
  logic       load_q, load_d;
  logic [1:0] age_q,  age_d;

  // A new issue always replaces the previous producer: the newest write wins.
  always_comb begin
    pend_d = pend_q;
    load_d = load_q;
    age_d  = age_q;
    if (issue_i) begin
      pend_d = 1'b1;
      load_d = load_i;
      age_d  = AGE_EX;
    end else if (pend_q) begin
      if (age_q == AGE_WB) begin
        pend_d = 1'b0;
        load_d = 1'b0;
        age_d  = AGE_NONE;
      end else begin
        age_d  = age_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      load_q <= 1'b0;
      age_q  <= AGE_NONE;
    end else begin
      pend_q <= pend_d;
      load_q <= load_d;
      age_q  <= age_d;
    end
  end

  assign pend_o = pend_q;
  assign load_o = load_q;
  assign age_o  = age_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer-side hazard tracker for the 5-stage MIPS
// pipeline. Tracks every register write from ID through EX/MEM/WB, raises
// stall/flush for load-use and early-branch hazards, and drains the pipe on
// HALT before reporting the CPU halted.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_instr_rs_D/rt_D         source registers of the ID instruction
//   i_use_rt_D, i_branch_D    ID reads rt / ID is a branch resolved in ID
//   i_valid_D                 ID holds a real instruction
//   i_reg_write_D, i_mem_to_reg_D, i_write_reg_D  destination info
//   i_halt_D                  ID holds HALT
//   o_stall_F/o_stall_D/o_flush_E  hold PC, hold IF/ID, bubble ID/EX
//   o_halted                  pipeline drained after HALT
//   o_busy                    at least one pending write tracked
//   o_stall_count             stall-cycle counter (HAZARD_STALL_STATS_EN only)
// Build option: define HAZARD_STALL_STATS_EN to add o_stall_count.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NB_REG       = NB_REG_DEFAULT,
  parameter int unsigned N_REGS       = 32,
  parameter int unsigned NB_STALL_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NB_REG-1:0] i_instr_rs_D,
  input  logic [NB_REG-1:0] i_instr_rt_D,
  input  logic              i_use_rt_D,
  input  logic              i_branch_D,
  input  logic              i_valid_D,
  input  logic              i_reg_write_D,
  input  logic              i_mem_to_reg_D,
  input  logic [NB_REG-1:0] i_write_reg_D,
  input  logic              i_halt_D,
  output logic              o_stall_F,
  output logic              o_stall_D,
  output logic              o_flush_E,
  output logic              o_halted,
  output logic              o_busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [NB_STALL_CNT-1:0] o_stall_count
`endif
);

  logic [N_REGS-1:0]      pend;
  logic [N_REGS-1:0]      is_load;
  logic [N_REGS-1:0][1:0] age;

  state_e state_q;
  logic   halted_q;
  logic   hz_rs, hz_rt, hazard, stall, issue, wr_issue;

  // Register 0 is hard-wired and never creates a dependency.
  assign pend[0]    = 1'b0;
  assign is_load[0] = 1'b0;
  assign age[0]     = AGE_NONE;

  for (genvar g = 1; g < N_REGS; g++) begin : g_entry
    hazard_reg_entry u_entry (
      .clk_i   (i_clk),
      .rst_ni  (i_reset),
      .issue_i (wr_issue && (i_write_reg_D == NB_REG'(g))),
      .load_i  (i_mem_to_reg_D),
      .pend_o  (pend[g]),
      .load_o  (is_load[g]),
      .age_o   (age[g])
    );
  end

  always_comb begin
    hz_rs  = src_hazard(pend[i_instr_rs_D], is_load[i_instr_rs_D],
                        age[i_instr_rs_D], i_branch_D);
    hz_rt  = i_use_rt_D &&
             src_hazard(pend[i_instr_rt_D], is_load[i_instr_rt_D],
                        age[i_instr_rt_D], i_branch_D);
    hazard = i_valid_D && (hz_rs || hz_rt) && (state_q == ST_RUN);
    // Outside RUN the front end is frozen regardless of the ID contents.
    stall  = hazard || (state_q != ST_RUN);
    issue  = i_valid_D && !stall;
    // HALT issues but never writes a register.
    wr_issue = issue && i_reg_write_D && !i_halt_D && (i_write_reg_D != '0);
  end

  assign o_busy = |pend;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (issue && i_halt_D) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!o_busy) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_stall_F = stall;
  assign o_stall_D = stall;
  assign o_flush_E = stall;
  assign o_halted  = halted_q;

`ifdef HAZARD_STALL_STATS_EN
  logic [NB_STALL_CNT-1:0] stall_cnt_q;

  // Only hazard stalls in RUN are counted; drain/halt freezes are not.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                          stall_cnt_q <= '0;
    else if (hazard && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign o_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard
// against a pipeline-slot reference model (EX/MEM/WB occupancy).
module tb_hazard_scoreboard;

`ifdef HAZARD_STALL_STATS_EN
  localparam int unsigned CNT_W = 3;
`else
  localparam int unsigned CNT_W = 32;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs = '0, rt = '0, wr = '0;
  logic       use_rt = 1'b0, br = 1'b0, valid = 1'b0, rw = 1'b0, ld = 1'b0, halt = 1'b0;
  logic       stall_F, stall_D, flush_E, halted, busy;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_STALL_STATS_EN
  hazard_scoreboard #(.NB_REG(5), .N_REGS(32), .NB_STALL_CNT(CNT_W)) dut (
`else
  hazard_scoreboard #(.NB_REG(5), .N_REGS(32)) dut (
`endif
    .i_clk(clk), .i_reset(rst_n),
    .i_instr_rs_D(rs), .i_instr_rt_D(rt), .i_use_rt_D(use_rt),
    .i_branch_D(br), .i_valid_D(valid), .i_reg_write_D(rw),
    .i_mem_to_reg_D(ld), .i_write_reg_D(wr), .i_halt_D(halt),
    .o_stall_F(stall_F), .o_stall_D(stall_D), .o_flush_E(flush_E),
    .o_halted(halted), .o_busy(busy)
`ifdef HAZARD_STALL_STATS_EN
    , .o_stall_count(stall_count)
`endif
  );

`ifndef HAZARD_STALL_STATS_EN
  assign stall_count = '0;
`endif

  // Reference model: which instruction sits in each downstream stage.
  typedef struct { bit v; bit [4:0] d; bit ld; } slot_t;
  slot_t m_ex, m_mem, m_wb;
  int    m_state;           // 0 run, 1 drain, 2 halted
  int    m_cnt;
  logic  last_stall;

  function automatic void m_clear();
    m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0};
    m_state = 0; m_cnt = 0;
  endfunction

  // Youngest in-flight producer of s decides.
  function automatic bit m_src_hz(bit [4:0] s, bit branch);
    if (s == 0) return 0;
    if (m_ex.v && m_ex.d == s)   return branch ? 1'b1 : m_ex.ld;
    if (m_mem.v && m_mem.d == s) return branch ? m_mem.ld : 1'b0;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [4:0] s, input bit [4:0] t, input bit ur,
                       input bit b, input bit w, input bit l, input bit [4:0] d, input bit h);
    valid = v; rs = s; rt = t; use_rt = ur; br = b; rw = w; ld = l; wr = d; halt = h;
  endtask

  // One clock: check at negedge, then advance the model at posedge.
  task automatic cycle(input string tag);
    bit hz, st, iss, mbusy;
    @(negedge clk);
    hz = valid && (m_state == 0) && (m_src_hz(rs, br) || (use_rt && m_src_hz(rt, br)));
    st = hz || (m_state != 0);
    mbusy = m_ex.v || m_mem.v || m_wb.v;
    last_stall = stall_D;
    chk({tag, ".stall_F"}, 32'(stall_F), 32'(st));
    chk({tag, ".stall_D"}, 32'(stall_D), 32'(st));
    chk({tag, ".flush_E"}, 32'(flush_E), 32'(st));
    chk({tag, ".halted"},  32'(halted),  32'(m_state == 2));
    chk({tag, ".busy"},    32'(busy),    32'(mbusy));
`ifdef HAZARD_STALL_STATS_EN
    chk({tag, ".count"},   32'(stall_count), 32'(m_cnt));
`endif
    @(posedge clk);
    iss = valid && !st;
    m_wb = m_mem; m_mem = m_ex;
    if (iss && rw && !halt && wr != 0) m_ex = '{1, wr, ld};
    else                               m_ex = '{0, 0, 0};
    if (m_state == 0 && iss && halt) m_state = 1;
    else if (m_state == 1 && !mbusy) m_state = 2;
    if (hz && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst.stall_F", 32'(stall_F), 0);
    chk("rst.flush_E", 32'(flush_E), 0);
    chk("rst.halted",  32'(halted),  0);
    chk("rst.busy",    32'(busy),    0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_clear();
  endtask

  initial begin
    m_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();
    chk("reset.count", 32'(stall_count), 0);

    // load-use: exactly one stall
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("lw8");   chk("lw8.nostall", 32'(last_stall), 0);
    drive(1, 8, 1, 1, 0, 1, 0, 9, 0); cycle("lu.a");  chk("lu.stall1", 32'(last_stall), 1);
    cycle("lu.b");                                    chk("lu.issue", 32'(last_stall), 0);
    // load followed by a consumer of $0 only
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("lw8b");
    drive(1, 0, 1, 1, 0, 1, 0, 9, 0); cycle("r0");    chk("r0.nostall", 32'(last_stall), 0);
    // ALU result into branch: one stall
    drive(1, 1, 2, 1, 0, 1, 0, 8, 0); cycle("add8");
    drive(1, 8, 2, 1, 1, 0, 0, 0, 0); cycle("beq.a"); chk("alu_beq.stall1", 32'(last_stall), 1);
    cycle("beq.b");                                   chk("alu_beq.go", 32'(last_stall), 0);
    // load into branch: two stalls
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("lw8c");
    drive(1, 8, 2, 1, 1, 0, 0, 0, 0); cycle("lb.a");  chk("ld_beq.stall1", 32'(last_stall), 1);
    cycle("lb.b");                                    chk("ld_beq.stall2", 32'(last_stall), 1);
    cycle("lb.c");                                    chk("ld_beq.go", 32'(last_stall), 0);
    // override: newest producer (add) decides
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("ov.lw");
    drive(1, 1, 2, 1, 0, 1, 0, 8, 0); cycle("ov.add"); chk("ov.add_go", 32'(last_stall), 0);
    drive(1, 8, 2, 1, 1, 0, 0, 0, 0); cycle("ov.b1"); chk("ov.stall1", 32'(last_stall), 1);
    cycle("ov.b2");                                   chk("ov.go", 32'(last_stall), 0);

    // asynchronous reset in the middle of a load-use stall
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("rs.lw");
    drive(1, 8, 1, 1, 0, 1, 0, 9, 0);
    #2 chk("rs.pre_stall", 32'(stall_F), 1);
    rst_n = 1'b0;
    #1;
    chk("rs.stall_F", 32'(stall_F), 0);
    chk("rs.stall_D", 32'(stall_D), 0);
    chk("rs.flush_E", 32'(flush_E), 0);
    chk("rs.busy",    32'(busy),    0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_clear();
    cycle("rs.after");                                chk("rs.after_nostall", 32'(last_stall), 0);

`ifdef HAZARD_STALL_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("st.lw");
      drive(1, 8, 1, 1, 0, 1, 0, 9, 0); cycle("st.s"); cycle("st.i");
      if (i == 4) chk("stats.five", 32'(stall_count), 5);
    end
    chk("stats.saturate", 32'(stall_count), 7);
`endif

    // halt drain
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 5, 0); cycle("h.add5");
    drive(1, 0, 0, 0, 0, 1, 1, 6, 0); cycle("h.lw6");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1); cycle("h.halt");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && m_state != 2; i++) cycle("h.drain");
    chk("h.model_halted", 32'(m_state), 2);
    for (int i = 0; i < 4; i++) cycle("h.hold");
    chk("h.halted_held", 32'(halted), 1);
    chk("h.stall_held", 32'(stall_F), 1);
    drive(1, 1, 2, 1, 0, 1, 0, 7, 0); cycle("h.ignored");

    // HALT behind a hazard waits for the hazard to clear
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 8, 0); cycle("hz.lw");
    drive(1, 8, 0, 0, 0, 0, 0, 0, 1); cycle("hz.halt1"); chk("hz.halt_stall", 32'(last_stall), 1);
    cycle("hz.halt2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("hz.drain");
    chk("hz.halted", 32'(halted), 1);

    // randomized traffic on a few registers
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
      drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side hazard tracker for the 5-stage MIPS pipeline, and the counterpart of the forwarding unit.
- Records every register write as the instruction leaves ID and ages it through EX/MEM/WB.
- Generates stall (F, D) and bubble (flush E) controls for cases forwarding cannot cover: load-use, and branch comparator operands not yet in MEM.
- Runs a halt-drain FSM so the debug unit only sees a halted CPU once all pending writes have retired.

Parameters:
- NB_REG, 5, register index width
- N_REGS, 32, number of architectural registers
- NB_STALL_CNT, 32, width of stall statistics counter (optional feature only)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_instr_rs_D  in  NB_REG  rs of instruction in ID
- i_instr_rt_D  in  NB_REG  rt of instruction in ID
- i_use_rt_D  in  1  ID instruction reads rt (R-type, store, beq/bne)
- i_branch_D  in  1  ID instruction is a branch resolved in ID
- i_valid_D  in  1  ID holds a real instruction (not a bubble)
- i_reg_write_D  in  1  ID instruction writes a register
- i_mem_to_reg_D  in  1  ID instruction is a load
- i_write_reg_D  in  NB_REG  destination register (rd or rt, already muxed)
- i_halt_D  in  1  ID holds HALT
- o_stall_F  out  1  hold PC
- o_stall_D  out  1  hold IF/ID register
- o_flush_E  out  1  insert bubble into ID/EX
- o_halted  out  1  pipeline drained after HALT
- o_busy  out  1  at least one pending write tracked

Behaviour:
- State per register r (1..N_REGS-1): pend[r], load[r], age[r] (2 bits). Register 0 is never tracked.
- Issue occurs when i_valid_D & !o_stall_D & state==RUN.
  - If also i_reg_write_D & i_write_reg_D!=0: next cycle pend=1, age=1 (EX), load=i_mem_to_reg_D.
  - A new issue overrides any older entry for the same register; the newest producer wins.
- Aging, every cycle for each pending r not being re-issued:
  - age 1→2 (MEM), 2→3 (WB).
  - At age 3, pend clears on the next edge; the regfile writes first-half/reads second-half, so WB needs no stall.
- Source hazard for src s (rs always; rt only if i_use_rt_D), with s!=0 and pend[s]:
  - Non-branch: hazard if load[s] & age==1.
  - Branch: hazard if age==1, or load[s] & age==2.
- stall = i_valid_D & any hazard, in RUN. The stall output is combinational from registered state plus ID inputs, so it is seen in the same cycle.
- On stall: o_stall_F=o_stall_D=o_flush_E=1 and no issue that cycle. Aging continues, so every stall ends within at most 2 cycles.
- FSM RUN / DRAIN / HALTED:
  - RUN→DRAIN when i_valid_D & i_halt_D & no hazard; HALT itself issues with no register write.
  - DRAIN: o_stall_F=o_stall_D=o_flush_E=1 each cycle. →HALTED when no pend bit is set.
  - HALTED: same stall outputs held, o_halted=1. Only reset exits.
  - HALT while a hazard is present: stall first, enter DRAIN once the hazard clears.
- o_busy = OR of all pend bits.
- Reset (asynchronous, i_reset low): all pend/load/age cleared, state=RUN. All outputs become 0 immediately.
- Reset mid-stall: outputs drop during reset, and the tracker starts empty after release.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- Defined:
  - Adds output o_stall_count [NB_STALL_CNT-1:0], counting cycles with stall=1 in RUN. DRAIN and HALTED cycles are not counted.
  - Counter saturates at all-ones and resets to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2.
  - Age constants AGE_EX=2'd1, AGE_MEM=2'd2, AGE_WB=2'd3.
  - NB_REG default.
- One sub-module is natural: hazard_reg_entry, holding a single register's pend/load/age with issue/age/clear logic, instantiated N_REGS-1 times by generate. Hazard compare and FSM stay in the top.

Test Plan:
- lw $8 issues; next cycle add $9,$8,$1 in ID -> exactly 1 stall cycle (stall_F/D/flush_E=1), then issue; no stall if rs=$0.
- add $8 then beq $8,$2 in ID next cycle -> 1 stall cycle; lw $8 then beq $8 -> 2 consecutive stall cycles.
- lw $8, then add $8 (override), then beq $8 -> stall follows the newest producer: 1 cycle, not 2.
- add $5; lw $6; HALT -> DRAIN with stalls high until o_busy=0 (about 3 cycles), then o_halted=1 held indefinitely.
- Assert i_reset low during a load-use stall -> all outputs 0 asynchronously; after release, add $9,$8 issues with no stall.
- With HAZARD_STALL_STATS_EN: 5 load-use pairs -> o_stall_count=5; preload near max -> saturates at all-ones.
